// File: rtl/wb_trace_monitor.sv
// wb_trace_monitor: writeback trace FIFO, performance counters, no-retire watchdog
// and shadow-register compare port for the pipelined_cpu writeback stage.
`default_nettype none

module wb_trace_monitor #(
  parameter int DATA_WIDTH             = 32,
  parameter int REG_FILE_ADDRESS_WIDTH = 5,
  parameter int TRACE_DEPTH            = 16,
  parameter int TIMEOUT_CYCLES         = 200,
  parameter int CNT_WIDTH              = 32
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           enable,
  input  logic                                           wrap_mode,
  input  logic                                           RegWriteW,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0]              RdW,
  input  logic [DATA_WIDTH-1:0]                          ResultW,
  input  logic [DATA_WIDTH-1:0]                          PCW,
  input  logic                                           StallFetch,
  input  logic                                           StallDecode,
  input  logic                                           FlushDecode,
  input  logic                                           FlushExecute,
  output logic                                           trace_valid,
  input  logic                                           trace_ready,
  output logic [2*DATA_WIDTH+REG_FILE_ADDRESS_WIDTH-1:0] trace_data,
  output logic [$clog2(TRACE_DEPTH):0]                   trace_count,
  output logic                                           overflow,
  output logic [CNT_WIDTH-1:0]                           cycle_count,
  output logic [CNT_WIDTH-1:0]                           retire_count,
  output logic [CNT_WIDTH-1:0]                           stall_count,
  output logic [CNT_WIDTH-1:0]                           flush_count,
  output logic                                           timeout,
  input  logic                                           chk_valid,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0]              chk_addr,
  input  logic [DATA_WIDTH-1:0]                          chk_data,
  output logic                                           chk_done,
  output logic                                           chk_match,
  input  logic                                           clear
);

  localparam int PTR_W   = $clog2(TRACE_DEPTH);
  localparam int ENTRY_W = 2*DATA_WIDTH + REG_FILE_ADDRESS_WIDTH;
  localparam int NREG    = 1 << REG_FILE_ADDRESS_WIDTH;
  localparam int IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PTR_W:0]     PTR_ONE  = (PTR_W+1)'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [IDLE_W-1:0]  IDLE_ONE = IDLE_W'(1);
  localparam logic [IDLE_W-1:0]  IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

  typedef enum logic {S_IDLE = 1'b0, S_CMP = 1'b1} chk_state_t;

  logic [ENTRY_W-1:0]    mem_q [TRACE_DEPTH];
  logic [PTR_W:0]        wptr_q, rptr_q;
  logic [DATA_WIDTH-1:0] shadow_q [NREG];
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic                  overflow_q, timeout_q;
  logic [CNT_WIDTH-1:0]  cycle_q, retire_q, stall_q, flush_q;
  chk_state_t            chk_state_q;
  logic                  chk_done_q, chk_match_q;

  logic                  w_retire, w_empty, w_full, w_pop, w_wr, w_drop_or_ovw;
  logic [DATA_WIDTH-1:0] w_chk_val;

  assign w_retire = enable & RegWriteW & (RdW != '0);
  assign w_empty  = (wptr_q == rptr_q);
  assign w_full   = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                    (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign w_pop    = ~w_empty & trace_ready;
  // A push into a full FIFO lands only if a pop frees a slot or wrap mode evicts the head.
  assign w_wr          = w_retire & (~w_full | w_pop | wrap_mode) & ~clear;
  assign w_drop_or_ovw = w_retire & w_full & ~w_pop;

  assign trace_valid = ~w_empty;
  assign trace_count = wptr_q - rptr_q;
  assign trace_data  = w_empty ? '0 : mem_q[rptr_q[PTR_W-1:0]];
  assign overflow    = overflow_q;
  assign timeout     = timeout_q;
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;
  assign stall_count  = stall_q;
  assign flush_count  = flush_q;
  assign chk_done    = chk_done_q;
  assign chk_match   = chk_match_q;

  always_ff @(posedge clk) begin
    if (w_wr) mem_q[wptr_q[PTR_W-1:0]] <= {PCW, RdW, ResultW};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (w_wr) wptr_q <= wptr_q + PTR_ONE;
      if (w_pop || w_drop_or_ovw && wrap_mode) rptr_q <= rptr_q + PTR_ONE;
      if (w_drop_or_ovw) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) shadow_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NREG; i++) shadow_q[i] <= '0;
    end else if (w_retire) begin
      shadow_q[RdW] <= ResultW;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q  <= '0;
      retire_q <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else if (clear) begin
      cycle_q  <= '0;
      retire_q <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else if (enable) begin
      if (cycle_q != '1) cycle_q <= cycle_q + CNT_ONE;
      if (w_retire && retire_q != '1) retire_q <= retire_q + CNT_ONE;
      if ((StallFetch || StallDecode) && stall_q != '1) stall_q <= stall_q + CNT_ONE;
      if ((FlushDecode || FlushExecute) && flush_q != '1) flush_q <= flush_q + CNT_ONE;
    end
  end

  always_comb begin
    idle_d = idle_q;
    if (w_retire) idle_d = '0;
    else if (enable && idle_q != IDLE_MAX) idle_d = idle_q + IDLE_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else if (clear) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q <= idle_d;
      if (idle_d == IDLE_MAX) timeout_q <= 1'b1;
    end
  end

  // Forward a same-cycle retire so the compare sees the value being written now.
  always_comb begin
    w_chk_val = shadow_q[chk_addr];
    if (chk_addr == '0) w_chk_val = '0;
    else if (w_retire && RdW == chk_addr) w_chk_val = ResultW;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_state_q <= S_IDLE;
      chk_done_q  <= 1'b0;
      chk_match_q <= 1'b0;
    end else if (clear) begin
      chk_state_q <= S_IDLE;
      chk_done_q  <= 1'b0;
      chk_match_q <= 1'b0;
    end else begin
      case (chk_state_q)
        S_IDLE: begin
          if (chk_valid) begin
            chk_state_q <= S_CMP;
            chk_done_q  <= 1'b1;
            chk_match_q <= (w_chk_val == chk_data);
          end
        end
        default: begin
          chk_state_q <= S_IDLE;
          chk_done_q  <= 1'b0;
          chk_match_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_trace_monitor.sv
// tb_wb_trace_monitor: directed self-checking bench for wb_trace_monitor.
`default_nettype none

module tb_wb_trace_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, wrap_mode, RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW, PCW;
  logic        StallFetch, StallDecode, FlushDecode, FlushExecute;
  logic        trace_valid, trace_ready;
  logic [68:0] trace_data;
  logic [4:0]  trace_count;
  logic        overflow, timeout;
  logic [31:0] cycle_count, retire_count, stall_count, flush_count;
  logic        chk_valid;
  logic [4:0]  chk_addr;
  logic [31:0] chk_data;
  logic        chk_done, chk_match, clear;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  wb_trace_monitor dut (
    .clk(clk), .rst(rst), .enable(enable), .wrap_mode(wrap_mode),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .PCW(PCW),
    .StallFetch(StallFetch), .StallDecode(StallDecode),
    .FlushDecode(FlushDecode), .FlushExecute(FlushExecute),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
    .trace_count(trace_count), .overflow(overflow),
    .cycle_count(cycle_count), .retire_count(retire_count),
    .stall_count(stall_count), .flush_count(flush_count), .timeout(timeout),
    .chk_valid(chk_valid), .chk_addr(chk_addr), .chk_data(chk_data),
    .chk_done(chk_done), .chk_match(chk_match), .clear(clear)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic retire(input logic [4:0] rd, input logic [31:0] res, input logic [31:0] pc);
    RegWriteW = 1'b1; RdW = rd; ResultW = res; PCW = pc;
    tick();
    RegWriteW = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b0; wrap_mode = 1'b0; RegWriteW = 1'b0; RdW = '0;
    ResultW = '0; PCW = '0; StallFetch = 1'b0; StallDecode = 1'b0;
    FlushDecode = 1'b0; FlushExecute = 1'b0; trace_ready = 1'b0;
    chk_valid = 1'b0; chk_addr = '0; chk_data = '0; clear = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    total_cnt++;
    if (trace_valid !== 1'b0 || trace_count !== 5'd0 || trace_data !== 69'd0)
      $display("FAIL reset_fifo: valid=%b count=%0d data=%h want 0/0/0", trace_valid, trace_count, trace_data);
    else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0 || timeout !== 1'b0 || chk_done !== 1'b0 || chk_match !== 1'b0)
      $display("FAIL reset_flags: ovf=%b to=%b done=%b match=%b want 0", overflow, timeout, chk_done, chk_match);
    else pass_cnt++;
    total_cnt++;
    if (cycle_count !== 32'd0 || retire_count !== 32'd0 || stall_count !== 32'd0 || flush_count !== 32'd0)
      $display("FAIL reset_counters: cyc=%0d ret=%0d stl=%0d fl=%0d want 0", cycle_count, retire_count, stall_count, flush_count);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [68:0] exp [3];
    exp[0] = {32'd0, 5'd1, 32'd5};
    exp[1] = {32'd4, 5'd2, 32'd7};
    exp[2] = {32'd8, 5'd3, 32'd9};
    enable = 1'b1; wrap_mode = 1'b0; trace_ready = 1'b0;
    retire(5'd1, 32'd5, 32'd0);
    total_cnt++;
    if (trace_data !== exp[0])
      $display("FAIL basic_latency: got %h want %h", trace_data, exp[0]);
    else pass_cnt++;
    retire(5'd2, 32'd7, 32'd4);
    retire(5'd3, 32'd9, 32'd8);
    total_cnt++;
    if (trace_count !== 5'd3 || retire_count !== 32'd3)
      $display("FAIL basic_count: count=%0d retires=%0d want 3/3", trace_count, retire_count);
    else pass_cnt++;
    trace_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (trace_valid !== 1'b1 || trace_data !== exp[i])
        $display("FAIL basic_pop%0d: valid=%b got %h want %h", i, trace_valid, trace_data, exp[i]);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (trace_valid !== 1'b0 || trace_count !== 5'd0 || overflow !== 1'b0)
      $display("FAIL basic_empty: valid=%b count=%0d ovf=%b want 0/0/0", trace_valid, trace_count, overflow);
    else pass_cnt++;
    trace_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] first, last;
    do_clear();
    wrap_mode = 1'b1;
    for (int i = 1; i <= 20; i++) retire(5'((i % 31) + 1), 32'(i), 32'(i * 4));
    total_cnt++;
    if (trace_count !== 5'd16 || overflow !== 1'b1 || trace_data[31:0] !== 32'd5)
      $display("FAIL wrap_full: count=%0d ovf=%b head=%0d want 16/1/5", trace_count, overflow, trace_data[31:0]);
    else pass_cnt++;
    trace_ready = 1'b1;
    retire(5'd9, 32'd100, 32'd400);
    total_cnt++;
    if (trace_count !== 5'd16 || trace_data[31:0] !== 32'd6)
      $display("FAIL wrap_push_pop: count=%0d head=%0d want 16/6", trace_count, trace_data[31:0]);
    else pass_cnt++;
    first = trace_data[31:0];
    last = '0;
    for (int i = 0; i < 16; i++) begin
      last = trace_data[31:0];
      tick();
    end
    total_cnt++;
    if (first !== 32'd6 || last !== 32'd100 || trace_valid !== 1'b0)
      $display("FAIL wrap_drain: first=%0d last=%0d valid=%b want 6/100/0", first, last, trace_valid);
    else pass_cnt++;
    trace_ready = 1'b0;
  endtask

  task automatic test_drop();
    logic [31:0] first, last;
    do_clear();
    wrap_mode = 1'b0;
    for (int i = 1; i <= 20; i++) retire(5'((i % 31) + 1), 32'(i), 32'(i * 4));
    total_cnt++;
    if (trace_count !== 5'd16 || overflow !== 1'b1 || retire_count !== 32'd20)
      $display("FAIL drop_full: count=%0d ovf=%b retires=%0d want 16/1/20", trace_count, overflow, retire_count);
    else pass_cnt++;
    trace_ready = 1'b1;
    first = trace_data[31:0];
    last = '0;
    for (int i = 0; i < 16; i++) begin
      last = trace_data[31:0];
      tick();
    end
    total_cnt++;
    if (first !== 32'd1 || last !== 32'd16 || trace_count !== 5'd0)
      $display("FAIL drop_drain: first=%0d last=%0d count=%0d want 1/16/0", first, last, trace_count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (trace_count !== 5'd0 || trace_valid !== 1'b0)
      $display("FAIL drop_pop_empty: count=%0d valid=%b want 0/0", trace_count, trace_valid);
    else pass_cnt++;
    trace_ready = 1'b0;
  endtask

  task automatic test_x0();
    do_clear();
    retire(5'd0, 32'hDEAD, 32'h40);
    total_cnt++;
    if (trace_count !== 5'd0 || retire_count !== 32'd0)
      $display("FAIL x0_retire: count=%0d retires=%0d want 0/0", trace_count, retire_count);
    else pass_cnt++;
    chk_valid = 1'b1; chk_addr = 5'd0; chk_data = 32'd0;
    tick();
    chk_valid = 1'b0;
    total_cnt++;
    if (chk_done !== 1'b1 || chk_match !== 1'b1)
      $display("FAIL x0_check: done=%b match=%b want 1/1", chk_done, chk_match);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (chk_done !== 1'b0)
      $display("FAIL x0_done_pulse: done=%b want 0", chk_done);
    else pass_cnt++;
  endtask

  task automatic test_check();
    retire(5'd5, 32'h11, 32'h100);
    chk_valid = 1'b1; chk_addr = 5'd5; chk_data = 32'h11;
    tick();
    total_cnt++;
    if (chk_done !== 1'b1 || chk_match !== 1'b1)
      $display("FAIL chk_match: done=%b match=%b want 1/1", chk_done, chk_match);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (chk_done !== 1'b0)
      $display("FAIL chk_ignore_in_cmp: done=%b want 0", chk_done);
    else pass_cnt++;
    chk_valid = 1'b0;
    tick();
    chk_valid = 1'b1; chk_data = 32'h12;
    tick();
    chk_valid = 1'b0;
    total_cnt++;
    if (chk_done !== 1'b1 || chk_match !== 1'b0)
      $display("FAIL chk_mismatch: done=%b match=%b want 1/0", chk_done, chk_match);
    else pass_cnt++;
    tick();
    chk_valid = 1'b1; chk_data = 32'h22;
    retire(5'd5, 32'h22, 32'h104);
    chk_valid = 1'b0;
    total_cnt++;
    if (chk_done !== 1'b1 || chk_match !== 1'b1)
      $display("FAIL chk_forward: done=%b match=%b want 1/1", chk_done, chk_match);
    else pass_cnt++;
    tick();
    chk_valid = 1'b1; chk_data = 32'h11;
    tick();
    chk_valid = 1'b0;
    total_cnt++;
    if (chk_done !== 1'b1 || chk_match !== 1'b0)
      $display("FAIL chk_stale: done=%b match=%b want 1/0", chk_done, chk_match);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_watchdog();
    do_clear();
    StallFetch = 1'b1;
    for (int i = 0; i < 199; i++) tick();
    total_cnt++;
    if (timeout !== 1'b0)
      $display("FAIL wd_early: timeout=%b want 0 after 199 cycles", timeout);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (timeout !== 1'b1 || stall_count !== 32'd200 || cycle_count !== 32'd200)
      $display("FAIL wd_fire: timeout=%b stalls=%0d cycles=%0d want 1/200/200", timeout, stall_count, cycle_count);
    else pass_cnt++;
    StallFetch = 1'b0; FlushExecute = 1'b1;
    tick(); tick(); tick();
    FlushExecute = 1'b0;
    total_cnt++;
    if (timeout !== 1'b1 || flush_count !== 32'd3 || stall_count !== 32'd200)
      $display("FAIL wd_sticky: timeout=%b flushes=%0d stalls=%0d want 1/3/200", timeout, flush_count, stall_count);
    else pass_cnt++;
    enable = 1'b0;
    tick(); tick();
    total_cnt++;
    if (cycle_count !== 32'd203)
      $display("FAIL enable_gate: cycles=%0d want 203", cycle_count);
    else pass_cnt++;
    enable = 1'b1;
    do_clear();
    total_cnt++;
    if (timeout !== 1'b0 || cycle_count !== 32'd0 || stall_count !== 32'd0 || flush_count !== 32'd0 || retire_count !== 32'd0)
      $display("FAIL wd_clear: to=%b cyc=%0d stl=%0d fl=%0d ret=%0d want 0", timeout, cycle_count, stall_count, flush_count, retire_count);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    retire(5'd3, 32'd7, 32'd12);
    chk_valid = 1'b1; chk_addr = 5'd3; chk_data = 32'd7;
    tick();
    chk_valid = 1'b0;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (chk_done !== 1'b0 || trace_count !== 5'd0 || retire_count !== 32'd0 || cycle_count !== 32'd0)
      $display("FAIL async_reset: done=%b count=%0d ret=%0d cyc=%0d want 0", chk_done, trace_count, retire_count, cycle_count);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    tick();
    chk_valid = 1'b1; chk_addr = 5'd3; chk_data = 32'd0;
    tick();
    chk_valid = 1'b0;
    total_cnt++;
    if (chk_done !== 1'b1 || chk_match !== 1'b1)
      $display("FAIL async_reset_shadow: done=%b match=%b want 1/1", chk_done, chk_match);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_drop();
    test_x0();
    test_check();
    test_watchdog();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_trace_monitor.md
Name: wb_trace_monitor

Overview:
Synthesizable debug monitor attached to the writeback stage and hazard unit of pipelined_cpu. It captures every register-file writeback into a parametrised trace FIFO and maintains performance counters (cycles, retires, stalls, flushes). It also provides a no-retire watchdog and a shadow-register compare port, so the checks currently done by bench tasks run in hardware and on FPGA.

Parameters:
DATA_WIDTH, 32, width of ResultW and PC.
REG_FILE_ADDRESS_WIDTH, 5, width of RdW and check address.
TRACE_DEPTH, 16, trace FIFO entries; must be a power of 2 and at least 2.
TIMEOUT_CYCLES, 200, consecutive no-retire cycles before timeout asserts; must be at least 1.
CNT_WIDTH, 32, width of all counters.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
enable  in  1  monitor active; when 0, nothing is captured or counted.
wrap_mode  in  1  1 = overwrite oldest entry when full; 0 = drop new entries when full.
RegWriteW  in  1  writeback valid.
RdW  in  REG_FILE_ADDRESS_WIDTH  writeback destination.
ResultW  in  DATA_WIDTH  writeback data.
PCW  in  DATA_WIDTH  PC of the writeback instruction.
StallFetch, StallDecode, FlushDecode, FlushExecute  in  1 each  hazard unit outputs.
trace_valid  out  1  FIFO non-empty.
trace_ready  in  1  consumer pops the head entry.
trace_data  out  2*DATA_WIDTH+REG_FILE_ADDRESS_WIDTH  head entry as {PCW, RdW, ResultW}.
trace_count  out  $clog2(TRACE_DEPTH)+1  current occupancy.
overflow  out  1  sticky; set on any drop or overwrite.
cycle_count, retire_count, stall_count, flush_count  out  CNT_WIDTH each  performance counters.
timeout  out  1  sticky watchdog flag.
chk_valid  in  1  compare request.
chk_addr  in  REG_FILE_ADDRESS_WIDTH  register to compare.
chk_data  in  DATA_WIDTH  expected value.
chk_done  out  1  one-cycle pulse with the result.
chk_match  out  1  compare result; valid while chk_done is high.
clear  in  1  synchronous clear of FIFO, counters, sticky flags and shadow register file.

Behaviour:
- Reset (rst=0, asynchronous) or clear=1 on a clock edge: FIFO empty, trace_valid=0, trace_count=0, trace_data=0, all counters 0, overflow=0, timeout=0, chk_done=0, chk_match=0, all shadow registers 0. clear takes priority over every other event in that cycle.
- Retire event: enable & RegWriteW & (RdW!=0). Writes to x0 are neither captured nor counted.
- On a retire event:
  - Push {PCW, RdW, ResultW} into the FIFO.
  - Write ResultW into shadow[RdW].
  - Increment retire_count.
  - The new entry is visible on trace_data on the next cycle (1-cycle latency).
- FIFO is first-word-fall-through. A pop occurs when trace_valid & trace_ready; trace_ready while empty has no effect.
- Simultaneous push and pop: occupancy is unchanged; allowed when full.
- Push while full with no pop:
  - wrap_mode=1: oldest entry discarded, read pointer advances, trace_count stays at TRACE_DEPTH, overflow set.
  - wrap_mode=0: new entry dropped, overflow set.
  - In both modes the shadow register file and retire_count still update.
- Pointers have log2(TRACE_DEPTH) bits plus one wrap bit; full and empty are derived from them.
- Counters, gated by enable:
  - cycle_count increments every cycle.
  - stall_count increments when StallFetch|StallDecode.
  - flush_count increments when FlushDecode|FlushExecute.
  - All counters saturate at all-ones; they never wrap.
- Watchdog:
  - Internal counter idle_cnt resets to 0 on each retire event and increments otherwise while enable=1.
  - When idle_cnt reaches TIMEOUT_CYCLES, timeout sets and stays set until rst or clear.
  - enable=0 freezes idle_cnt.
- Check port, a 2-state FSM:
  - IDLE -> CMP when chk_valid is high; chk_addr and chk_data are registered.
  - CMP: chk_done=1 and chk_match=(shadow[addr]==data). The FSM always returns to IDLE the next cycle.
  - chk_valid is ignored while in CMP.
  - Forwarding rule: if a retire event to the same register occurs in the cycle the request is registered, the compare uses the new value.
  - Checking x0 compares against 0.
- Reset mid-operation (rst asserted during a CMP or a push) aborts immediately; no partial state survives.

Test Plan:
- Reset, then 3 retires (RdW=1/2/3, ResultW=5/7/9, PCW=0/4/8), trace_ready=0 -> trace_count=3; pop in order yields {0,1,5}, {4,2,7}, {8,3,9}; retire_count=3.
- wrap_mode=1, TRACE_DEPTH=16, 20 retires with ResultW=1..20, no pops -> trace_count=16, overflow=1, first popped ResultW=5.
- wrap_mode=0, same stimulus -> trace_count=16, overflow=1, first popped ResultW=1, last popped ResultW=16.
- Retire with RdW=0, ResultW=0xDEAD -> no FIFO push, retire_count unchanged; check chk_addr=0, chk_data=0 -> chk_done pulse with chk_match=1.
- Retire x5=0x11, then check (5, 0x11) -> match=1; check (5, 0x12) -> match=0; same-cycle retire x5=0x22 with check (5, 0x22) -> match=1.
- enable=1, no retires for 200 cycles with StallFetch held high -> timeout=1 at cycle 200, stall_count=200; clear -> all counters 0, timeout=0.
